// File: rtl/anti_jitter_if.sv
// Button bundle between the board pins and the debouncer: raw levels in, clean levels and press strobes out.
`timescale 1ns/1ps

interface anti_jitter_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] btn_in;
    logic [WIDTH-1:0] btn_out;
    logic [WIDTH-1:0] btn_pulse;

    modport master (
        output btn_in,
        input  btn_out,
        input  btn_pulse
    );

    modport slave (
        input  btn_in,
        output btn_out,
        output btn_pulse
    );
endinterface

// File: rtl/anti_jitter.sv
// Per-channel button debouncer with press strobe; define ANTI_JITTER_REPEAT_EN to add
// auto-repeat strobes while a button stays held.
`timescale 1ns/1ps

module anti_jitter #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic         clk,
    input  logic         rst,
    anti_jitter_if.slave bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    // Refuse to elaborate with a debounce length the counter logic cannot honour.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24) ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("anti_jitter: illegal parameter combination");
    end

`ifdef ANTI_JITTER_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX) + 1;
    localparam logic [REP_W-1:0] REP_ZERO        = {REP_W{1'b0}};
    localparam logic [REP_W-1:0] REP_ONE         = REP_W'(1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
`endif

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] out_vec_s;
    logic [WIDTH-1:0] pulse_vec_s;

    // Two-flop synchronizer on every raw pin before any decision logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= {WIDTH{1'b0}};
            sync2_r <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= bus.btn_in;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t           state_r;
        state_t           state_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_s;
        logic             out_r;
        logic             out_s;
        logic             pulse_r;
        logic             pulse_s;
`ifdef ANTI_JITTER_REPEAT_EN
        logic [REP_W-1:0] rep_cnt_r;
        logic [REP_W-1:0] rep_cnt_s;
        logic             rep_armed_r;
        logic             rep_armed_s;
`endif

        // Next-state, debounce count and strobe for this channel.
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            out_s   = out_r;
            pulse_s = 1'b0;
`ifdef ANTI_JITTER_REPEAT_EN
            // Anything other than staying in HIGH restarts the repeat timing.
            rep_cnt_s   = REP_ZERO;
            rep_armed_s = 1'b0;
`endif
            case (state_r)
                ST_LOW: begin
                    out_s = 1'b0;
                    if (sync2_r[i]) begin
                        state_s = ST_WAIT_HIGH;
                        cnt_s   = CNT_ONE;
                    end else begin
                        cnt_s = CNT_ZERO;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!sync2_r[i]) begin
                        state_s = ST_LOW;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r >= CNT_LAST) begin
                        state_s = ST_HIGH;
                        cnt_s   = CNT_ZERO;
                        out_s   = 1'b1;
                        pulse_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    out_s = 1'b1;
                    if (!sync2_r[i]) begin
                        state_s = ST_WAIT_LOW;
                        cnt_s   = CNT_ONE;
                    end else begin
                        cnt_s = CNT_ZERO;
`ifdef ANTI_JITTER_REPEAT_EN
                        // First interval is the initial delay, later ones the period.
                        if (rep_cnt_r >= (rep_armed_r ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
                            pulse_s     = 1'b1;
                            rep_cnt_s   = REP_ZERO;
                            rep_armed_s = 1'b1;
                        end else begin
                            rep_cnt_s   = rep_cnt_r + REP_ONE;
                            rep_armed_s = rep_armed_r;
                        end
`endif
                    end
                end
                ST_WAIT_LOW: begin
                    if (sync2_r[i]) begin
                        state_s = ST_HIGH;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r >= CNT_LAST) begin
                        state_s = ST_LOW;
                        cnt_s   = CNT_ZERO;
                        out_s   = 1'b0;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_LOW;
                    cnt_s   = CNT_ZERO;
                    out_s   = 1'b0;
                end
            endcase
        end

        // Channel state, counters and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r <= ST_LOW;
                cnt_r   <= CNT_ZERO;
                out_r   <= 1'b0;
                pulse_r <= 1'b0;
`ifdef ANTI_JITTER_REPEAT_EN
                rep_cnt_r   <= REP_ZERO;
                rep_armed_r <= 1'b0;
`endif
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                out_r   <= out_s;
                pulse_r <= pulse_s;
`ifdef ANTI_JITTER_REPEAT_EN
                rep_cnt_r   <= rep_cnt_s;
                rep_armed_r <= rep_armed_s;
`endif
            end
        end

        assign out_vec_s[i]   = out_r;
        assign pulse_vec_s[i] = pulse_r;
    end

    assign bus.btn_out   = out_vec_s;
    assign bus.btn_pulse = pulse_vec_s;

endmodule

// File: tb/tb_anti_jitter.sv
// Directed bench for anti_jitter with short debounce/repeat parameters and an expectation queue.
`timescale 1ns/1ps

module tb_anti_jitter;

    localparam int W = 5;

`ifdef ANTI_JITTER_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] pulse;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    anti_jitter_if #(.WIDTH(W)) bus ();

    anti_jitter #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Queue the expectation for the coming edge, then compare after it.
    task automatic tick(input logic [W-1:0] eo, input logic [W-1:0] ep, input string tag);
        exp_t want;
        sb_q.push_back({eo, ep});
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        checks++;
        assert (bus.btn_out === want.out)
        else begin
            errors++;
            $error("FAIL %s btn_out observed=%b expected=%b", tag, bus.btn_out, want.out);
        end
        checks++;
        assert (bus.btn_pulse === want.pulse)
        else begin
            errors++;
            $error("FAIL %s btn_pulse observed=%b expected=%b", tag, bus.btn_pulse, want.pulse);
        end
    endtask

    // Clean press held for 'hold' edges then released: accept at edge 6, drop 6 edges after release.
    task automatic press_release(input logic [W-1:0] mask, input int hold, input string tag);
        for (int e = 1; e <= hold + 6; e++) begin
            bus.btn_in = (e <= hold) ? mask : 5'b00000;
            tick((e >= 6 && e < hold + 6) ? mask : 5'b00000,
                 (e == 6) ? mask : 5'b00000,
                 $sformatf("%s e%0d", tag, e));
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.btn_in = 5'b11111;
        for (int e = 1; e <= 3; e++) begin
            tick(5'b00000, 5'b00000, $sformatf("reset e%0d", e));
        end
        rst        = 1'b0;
        bus.btn_in = 5'b00000;
        for (int e = 1; e <= 2; e++) begin
            tick(5'b00000, 5'b00000, $sformatf("idle e%0d", e));
        end

        press_release(5'b00001, 8, "clean");

        // Bounce: high 3, low 1, high through edge 12, accepted at edge 10.
        for (int e = 1; e <= 18; e++) begin
            bus.btn_in = (e == 4 || e >= 13) ? 5'b00000 : 5'b00100;
            tick((e >= 10 && e <= 17) ? 5'b00100 : 5'b00000,
                 (e == 10) ? 5'b00100 : 5'b00000,
                 $sformatf("bounce e%0d", e));
        end

        // Held 30 edges: accepted at 6, repeats at 16,19,...,31 while still HIGH.
        for (int e = 1; e <= 36; e++) begin
            logic rep_hit;
            rep_hit    = REP_EN && (e >= 16) && (e <= 32) && (((e - 16) % 3) == 0);
            bus.btn_in = (e <= 30) ? 5'b00010 : 5'b00000;
            tick((e >= 6 && e <= 35) ? 5'b00010 : 5'b00000,
                 (e == 6 || rep_hit) ? 5'b00010 : 5'b00000,
                 $sformatf("repeat e%0d", e));
        end

        // rst at edge 5 (in WAIT_HIGH) and at edge 13 (in HIGH), pin held through 19.
        for (int e = 1; e <= 25; e++) begin
            rst        = (e == 5 || e == 13) ? 1'b1 : 1'b0;
            bus.btn_in = (e <= 19) ? 5'b00001 : 5'b00000;
            tick(((e >= 11 && e <= 12) || (e >= 19 && e <= 24)) ? 5'b00001 : 5'b00000,
                 (e == 11 || e == 19) ? 5'b00001 : 5'b00000,
                 $sformatf("midrst e%0d", e));
        end
        rst = 1'b0;

        press_release(5'b11000, 8, "simul");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached after %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
